// File: rtl/rvant_multdiv_slow_if.sv
// Request/response bundle between the EX stage and the iterative M-extension unit.
// The master side is EX (issues requests, consumes results); the slave side is the unit.
interface rvant_multdiv_slow_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             kill_i;
    logic             valid_o;
    logic [WIDTH-1:0] result_o;
    logic             ready_i;

    modport master (
        output valid_i, op_i, a_i, b_i, kill_i, ready_i,
        input  ready_o, valid_o, result_o
    );

    modport slave (
        input  valid_i, op_i, a_i, b_i, kill_i, ready_i,
        output ready_o, valid_o, result_o
    );
endinterface

// File: rtl/rvant_multdiv_slow.sv
// Iterative RV32M unit: one bit per cycle shift-add multiply and non-restoring
// divide on magnitudes, with sign correction applied in a single FIX cycle.
module rvant_multdiv_slow #(
    parameter int WIDTH = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    rvant_multdiv_slow_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    // Two's complement negate when neg is set (modulo 2^WIDTH).
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // Same as cond_neg, for the double-width product.
    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    logic [1:0]         state_q;
    logic [CW-1:0]      cnt_q;
    logic [2:0]         op_q;
    logic               sign_a_q;
    logic               sign_b_q;
    logic [WIDTH-1:0]   opb_q;     // |b|: multiplicand or divisor
    logic [2*WIDTH-1:0] acc_q;     // product accumulator, multiplier in low half
    logic [WIDTH:0]     rem_q;     // signed partial remainder
    logic [WIDTH-1:0]   quot_q;    // dividend shifts out as quotient shifts in
    logic [WIDTH-1:0]   result_q;

    // Request decode
    logic               accept;
    logic               a_signed_in;
    logic               b_signed_in;
    logic               sign_a_in;
    logic               sign_b_in;
    logic [WIDTH-1:0]   abs_a_in;
    logic [WIDTH-1:0]   abs_b_in;
    logic               b_zero_in;
    logic               ovf_in;
    logic               special_in;
    logic [WIDTH-1:0]   special_res;

    assign accept      = (state_q == S_IDLE) && bus.valid_i && !bus.kill_i;
    assign a_signed_in = (bus.op_i == OP_MULH) || (bus.op_i == OP_MULHSU) ||
                         (bus.op_i == OP_DIV)  || (bus.op_i == OP_REM);
    assign b_signed_in = (bus.op_i == OP_MULH) || (bus.op_i == OP_DIV) || (bus.op_i == OP_REM);
    assign sign_a_in   = a_signed_in && bus.a_i[WIDTH-1];
    assign sign_b_in   = b_signed_in && bus.b_i[WIDTH-1];
    assign abs_a_in    = cond_neg(bus.a_i, sign_a_in);
    assign abs_b_in    = cond_neg(bus.b_i, sign_b_in);
    assign b_zero_in   = (bus.b_i == '0);
    assign ovf_in      = ((bus.op_i == OP_DIV) || (bus.op_i == OP_REM)) &&
                         (bus.a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b_i == '1);
    assign special_in  = bus.op_i[2] && (b_zero_in || ovf_in);

    // Divide-by-zero and signed overflow results; op_i[1] selects REM/REMU.
    always_comb begin
        special_res = '0;
        if (b_zero_in) begin
            special_res = bus.op_i[1] ? bus.a_i : '1;
        end else begin
            special_res = bus.op_i[1] ? '0 : bus.a_i;
        end
    end

    // One iteration step of each algorithm
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_rem_next;
    logic [WIDTH-1:0]   div_quot_next;

    assign mul_sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next      = {mul_sum, acc_q[WIDTH-1:1]};
    assign div_shift     = {rem_q[WIDTH-1:0], quot_q[WIDTH-1]};
    assign div_rem_next  = rem_q[WIDTH] ? (div_shift + {1'b0, opb_q}) : (div_shift - {1'b0, opb_q});
    assign div_quot_next = {quot_q[WIDTH-2:0], ~div_rem_next[WIDTH]};

    // Final restore, sign correction and result selection
    logic [WIDTH-1:0]   rem_restored;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_res;

    assign rem_restored = rem_q[WIDTH] ? (rem_q[WIDTH-1:0] + opb_q) : rem_q[WIDTH-1:0];
    assign prod_fix     = cond_neg2(acc_q, sign_a_q ^ sign_b_q);
    assign quot_fix     = cond_neg(quot_q, sign_a_q ^ sign_b_q);
    assign rem_fix      = cond_neg(rem_restored, sign_a_q);

    // Pick the architectural result for the latched op
    always_comb begin
        fix_res = '0;
        case (op_q)
            OP_MUL:                        fix_res = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:               fix_res = quot_fix;
            default:                       fix_res = rem_fix;
        endcase
    end

    // Sequencer: IDLE -> CALC (WIDTH cycles) -> FIX -> DONE, kill returns to IDLE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q <= special_in ? S_DONE : S_CALC;
                        cnt_q   <= CW'(WIDTH-1);
                    end
                end
                S_CALC: begin
                    if (bus.kill_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == '0) state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    state_q <= S_IDLE;
                    if (!bus.kill_i) state_q <= S_DONE;
                end
                default: begin
                    if (bus.kill_i || bus.ready_i) state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Datapath: latch operands on accept, iterate in CALC, register result in FIX
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q     <= bus.op_i;
                sign_a_q <= sign_a_in;
                sign_b_q <= sign_b_in;
                opb_q    <= abs_b_in;
                acc_q    <= {{WIDTH{1'b0}}, abs_a_in};
                rem_q    <= '0;
                quot_q   <= abs_a_in;
                if (special_in) result_q <= special_res;
            end else if (state_q == S_CALC) begin
                if (op_q[2]) begin
                    rem_q  <= div_rem_next;
                    quot_q <= div_quot_next;
                end else begin
                    acc_q  <= mul_next;
                end
            end else if (state_q == S_FIX && !bus.kill_i) begin
                result_q <= fix_res;
            end
        end
    end

    assign bus.ready_o  = (state_q == S_IDLE);
    assign bus.valid_o  = (state_q == S_DONE);
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_rvant_multdiv_slow.sv
// Directed bench for rvant_multdiv_slow: arithmetic results, latency,
// special cases, back-pressure, kill and asynchronous reset.
module tb_rvant_multdiv_slow;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    rvant_multdiv_slow_if #(.WIDTH(32)) mif ();

    rvant_multdiv_slow #(.WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a request for one edge, then scramble the inputs.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mif.valid_i = 1'b1;
        mif.op_i    = op;
        mif.a_i     = a;
        mif.b_i     = b;
        @(posedge clk);
        #1;
        mif.valid_i = 1'b0;
        mif.op_i    = ~op;
        mif.a_i     = 32'hDEAD_BEEF;
        mif.b_i     = 32'h1234_5678;
    endtask

    // Wait (bounded) for valid_o; lat counts edges from the accept edge inclusive.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!mif.valid_o && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Full transaction with ready_i held high.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(op, a, b);
        wait_valid(lat);
        check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "_res"}, mif.result_o, exp);
        @(posedge clk);
        #1;
        check_val({tag, "_rdy"}, {31'd0, mif.ready_o}, 32'd1);
    endtask

    initial begin
        int lat;
        int seen;
        n_cmp       = 0;
        n_bad       = 0;
        rst         = 1'b1;
        mif.valid_i = 1'b0;
        mif.op_i    = 3'd0;
        mif.a_i     = '0;
        mif.b_i     = '0;
        mif.kill_i  = 1'b0;
        mif.ready_i = 1'b1;
        #12;
        check_val("rst_ready", {31'd0, mif.ready_o}, 32'd1);
        check_val("rst_valid", {31'd0, mif.valid_o}, 32'd0);
        check_val("rst_result", mif.result_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        run_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
        run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
        run_op("divu",   3'd5, 32'd100,        32'd7,         32'd14,        34);
        run_op("remu",   3'd7, 32'd100,        32'd7,         32'd2,         34);
        run_op("divu0",  3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        run_op("remu0",  3'd7, 32'd5,          32'd0,         32'd5,         1);
        run_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

        // Back-pressure: result held for 5 cycles, request pulse ignored
        mif.ready_i = 1'b0;
        issue(3'd0, 32'd1000, 32'd1000);
        wait_valid(lat);
        check_val("bp_lat", 32'(lat), 32'd34);
        for (int i = 0; i < 5; i++) begin
            check_val("bp_valid", {31'd0, mif.valid_o}, 32'd1);
            check_val("bp_res", mif.result_o, 32'd1_000_000);
            check_val("bp_rdy", {31'd0, mif.ready_o}, 32'd0);
            if (i == 1) begin
                mif.valid_i = 1'b1;
                mif.op_i    = 3'd5;
                mif.a_i     = 32'd5;
                mif.b_i     = 32'd0;
            end else begin
                mif.valid_i = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        mif.valid_i = 1'b0;
        check_val("bp_hold_res", mif.result_o, 32'd1_000_000);
        mif.ready_i = 1'b1;
        @(posedge clk);
        #1;
        check_val("bp_rel_rdy", {31'd0, mif.ready_o}, 32'd1);
        check_val("bp_rel_valid", {31'd0, mif.valid_o}, 32'd0);

        // Kill 10 cycles into CALC
        issue(3'd0, 32'd9, 32'd9);
        repeat (9) @(posedge clk);
        @(negedge clk);
        mif.kill_i = 1'b1;
        @(posedge clk);
        #1;
        mif.kill_i = 1'b0;
        check_val("kill_rdy", {31'd0, mif.ready_o}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (mif.valid_o) seen = 1;
            @(posedge clk);
            #1;
        end
        check_val("kill_novalid", 32'(seen), 32'd0);
        run_op("mul34", 3'd0, 32'd3, 32'd4, 32'd12, 34);

        // kill_i together with valid_i in IDLE blocks the accept
        @(negedge clk);
        mif.valid_i = 1'b1;
        mif.kill_i  = 1'b1;
        mif.op_i    = 3'd5;
        mif.a_i     = 32'd5;
        mif.b_i     = 32'd0;
        @(posedge clk);
        #1;
        mif.valid_i = 1'b0;
        mif.kill_i  = 1'b0;
        check_val("kidle_rdy", {31'd0, mif.ready_o}, 32'd1);
        check_val("kidle_valid", {31'd0, mif.valid_o}, 32'd0);

        // Asynchronous reset mid-CALC
        issue(3'd0, 32'd5, 32'd6);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("mrst_ready", {31'd0, mif.ready_o}, 32'd1);
        check_val("mrst_valid", {31'd0, mif.valid_o}, 32'd0);
        check_val("mrst_result", mif.result_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst", 3'd5, 32'd100, 32'd7, 32'd14, 34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
